multiplicador_arbitro: RTL and testbench
========================================

# multiplicador_arbitro

Round-robin arbiter and sequencer that shares one sequential shift-add multiplier (start/done handshake, 2N-bit product) between two requesters. It latches the winning requester's operands and drives the multiplier's start line until done is seen. It then returns the product with a one-cycle acknowledge and waits for done to drop before serving the next request. A watchdog detects a multiplier that never finishes and halts the arbiter with an error flag.

## Interface
- N, 8, operand width; product width is 2N
- TIMEOUT, 64, max cycles in RUN without m_done before fault; must be ≥ 2
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-low; shared with the multiplier (both reset in the same cycles)
- req0, req1  in  1  request, level; held until matching ack
- a0, b0, a1, b1  in  N  operands of requester 0/1, sampled only at grant
- gnt0, gnt1  out  1  high while that requester owns the multiplier
- ack0, ack1  out  1  one-cycle pulse: result valid on p_out
- p_out  out  2N  result bus, valid only in the ack cycle
- err  out  1  sticky watchdog fault
- m_start  out  1  multiplier start (level)
- m_a, m_b  out  N  multiplier operands
- m_done  in  1  multiplier done (level, held until m_start low)
- m_p  in  2N  multiplier product, valid while m_done=1

## Operation
- States: IDLE, RUN, ACK, DRAIN, HALT. Every output is registered.
- Reset (rst=0 at an edge): state IDLE, last-served pointer = 1 (req0 wins the first tie), all outputs 0, watchdog count 0.
- IDLE:
  - Only one req high → grant it.
  - Both high → grant the requester not equal to the pointer, then set the pointer to the winner.
  - On grant: latch a/b into m_a/m_b, set gnt_i=1 and m_start=1, clear the watchdog, go to RUN.
  - No req → stay in IDLE.
- RUN:
  - m_start held at 1. The watchdog increments each cycle.
  - m_done=1 → capture m_p into p_out, set m_start=0, go to ACK.
  - Watchdog reaches TIMEOUT with m_done still 0 → set m_start=0, pulse ack_i with p_out=0, set err=1, go to HALT.
- ACK:
  - ack_i=1 for exactly this cycle. gnt_i stays 1.
  - Go to DRAIN and clear gnt_i and ack_i.
- DRAIN:
  - Wait for m_done=0, then go to IDLE.
  - No grants are issued here. Requests are not lost; they are arbitrated in IDLE.
- HALT:
  - m_start=0, no grants, err=1, remains until reset.
- Operand changes after grant are ignored. m_a/m_b stay constant from grant until the next grant.
- If req_i drops mid-operation, the operation still completes and ack_i still pulses; the requester discards the result.
- A request raised during RUN/ACK/DRAIN by the other requester waits and wins at the next IDLE, since the pointer points away from it.
- The multiplier computes mod 2^(2N) unsigned. The arbiter passes m_p through unchanged.

## Timing
- A req sampled in IDLE at edge k gives gnt_i, m_start, m_a and m_b high/valid from k+1.
- If m_done is first sampled high at edge d, then ack_i and p_out are valid during the cycle after d, and m_start falls at the same edge.
- DRAIN lasts at least 1 cycle. The earliest next grant is 2 cycles after ack, provided m_done has already fallen.
- Minimum request-to-ack latency is 3 cycles (m_done high one cycle after start).
- If req and rst=0 coincide, reset wins and nothing is granted.
- Reset during RUN drops m_start the next cycle and discards the operation; no ack is issued.

## Test plan
- Single request: req0=1, a0=13, b0=11, model done 20 cycles after start → gnt0 at k+1, m_a=13, m_b=11, ack0 one cycle after done with p_out=143, gnt1/ack1 never high.
- Tie and round-robin:
  - req0 and req1 high from reset with a0=255,b0=255 and a1=2,b1=3.
  - ack0 comes first with 65025, then ack1 with 6.
  - Re-raise both together → req0 wins again, since the pointer is now 1.
- Back-to-back fairness: hold req0 continuously, assert req1 during req0's RUN → the next grant after req0's ack goes to req1.
- Operand stability: change a0 from 5 to 9 one cycle after gnt0 with b0=7 → m_a stays 5, and p_out=35 at ack0.
- Watchdog: multiplier model never raises m_done, TIMEOUT=64 → m_start falls 64 cycles after start, ack0 pulses with p_out=0, err=1 sticky, and later requests are not granted until rst=0 clears everything.
- Reset mid-RUN: assert rst=0 for 1 cycle in RUN → next cycle all outputs 0 and no ack; a fresh req1 is then served normally.

Source files
------------

// File: rtl/multiplicador_arbitro_if.sv
// Bundle between the two requesters / shared multiplier and the arbiter.
// The arbiter sits on the slave modport, the environment on the master one.
interface multiplicador_arbitro_if #(
  parameter int N = 8
);
  logic           req0;
  logic           req1;
  logic [N-1:0]   a0;
  logic [N-1:0]   b0;
  logic [N-1:0]   a1;
  logic [N-1:0]   b1;
  logic           gnt0;
  logic           gnt1;
  logic           ack0;
  logic           ack1;
  logic [2*N-1:0] p_out;
  logic           err;
  logic           m_start;
  logic [N-1:0]   m_a;
  logic [N-1:0]   m_b;
  logic           m_done;
  logic [2*N-1:0] m_p;
  logic [2:0]     dbg_state;

  modport slave (
    input  req0, req1, a0, b0, a1, b1, m_done, m_p,
    output gnt0, gnt1, ack0, ack1, p_out, err, m_start, m_a, m_b, dbg_state
  );

  modport master (
    output req0, req1, a0, b0, a1, b1, m_done, m_p,
    input  gnt0, gnt1, ack0, ack1, p_out, err, m_start, m_a, m_b, dbg_state
  );
endinterface

// File: rtl/multiplicador_arbitro.sv
// Round-robin arbiter/sequencer sharing one start/done multiplier between two
// requesters, with a watchdog that halts on a multiplier that never finishes.
//
// Handshakes: req_i is a level held until its ack_i; ack_i is a one-cycle
// pulse qualifying p_out. m_start is a level held until m_done is sampled
// high; m_done is a level the multiplier holds until m_start drops, and the
// arbiter waits for it to fall before arbitrating again.
module multiplicador_arbitro #(
  parameter int N       = 8,
  parameter int TIMEOUT = 64  // must be >= 2
) (
  input logic clk,
  input logic rst,
  multiplicador_arbitro_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    ACK   = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t         state_q, state_d;
  logic           ptr_q, ptr_d;      // last requester served
  logic           owner_q, owner_d;  // requester owning the current operation
  logic [WDW-1:0] wd_q, wd_d;
  logic           win;

  logic           gnt0_q, gnt0_d;
  logic           gnt1_q, gnt1_d;
  logic           ack0_q, ack0_d;
  logic           ack1_q, ack1_d;
  logic [2*N-1:0] p_q, p_d;
  logic           err_q, err_d;
  logic           start_q, start_d;
  logic [N-1:0]   ma_q, ma_d;
  logic [N-1:0]   mb_q, mb_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= 1'b1;
      owner_q <= 1'b0;
      wd_q    <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      p_q     <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      ma_q    <= '0;
      mb_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      wd_q    <= wd_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      p_q     <= p_d;
      err_q   <= err_d;
      start_q <= start_d;
      ma_q    <= ma_d;
      mb_q    <= mb_d;
    end
  end

  // On a tie the requester that was not served last wins; a lone request
  // wins outright. The pointer always follows the winner.
  always_comb begin
    win = bus.req1;
    if (bus.req0 && bus.req1) begin
      win = ~ptr_q;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    wd_d    = wd_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    p_d     = p_q;
    err_d   = err_q;
    start_d = start_q;
    ma_d    = ma_q;
    mb_d    = mb_q;

    case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          owner_d = win;
          ptr_d   = win;
          ma_d    = win ? bus.a1 : bus.a0;
          mb_d    = win ? bus.b1 : bus.b0;
          gnt0_d  = ~win;
          gnt1_d  = win;
          start_d = 1'b1;
          wd_d    = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (bus.m_done) begin
          p_d     = bus.m_p;
          start_d = 1'b0;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          state_d = ACK;
        end else if (wd_q == WD_LAST) begin
          // Release the requester with a zero result so it is not stuck.
          p_d     = '0;
          start_d = 1'b0;
          ack0_d  = ~owner_q;
          ack1_d  = owner_q;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          err_d   = 1'b1;
          wd_d    = wd_q + 1'b1;
          state_d = HALT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      ACK: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        p_d     = '0;
        state_d = DRAIN;
      end

      DRAIN: begin
        if (!bus.m_done) begin
          state_d = IDLE;
        end
      end

      HALT: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        start_d = 1'b0;
        err_d   = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.p_out     = p_q;
  assign bus.err       = err_q;
  assign bus.m_start   = start_q;
  assign bus.m_a       = ma_q;
  assign bus.m_b       = mb_q;
  assign bus.dbg_state = state_q;

  a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst)
    !(gnt0_q && gnt1_q));
  a_ack_onehot : assert property (@(posedge clk) disable iff (!rst)
    !(ack0_q && ack1_q));
  a_ack_pulse : assert property (@(posedge clk) disable iff (!rst)
    (ack0_q || ack1_q) |=> !(ack0_q || ack1_q));

endmodule

// File: tb/tb_multiplicador_arbitro.sv
// Directed bench for multiplicador_arbitro: a behavioural shift-add multiplier
// model, directed requests, and a scoreboard popped on every ack pulse.
module tb_multiplicador_arbitro;

  localparam int N = 8;
  localparam int W = 2 * N + 1;  // {requester id, product}

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   mul_delay;
  int   mul_hang;
  int   mcnt;
  logic [W-1:0] exp_q[$];

  multiplicador_arbitro_if #(.N(N)) bus ();

  multiplicador_arbitro #(.N(N), .TIMEOUT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // multiplier model: done mul_delay cycles after start, held until start drops
  always @(posedge clk) begin
    if (!rst) begin
      bus.m_done <= 1'b0;
      bus.m_p    <= '0;
      mcnt       <= 0;
    end else if (!bus.m_start) begin
      bus.m_done <= 1'b0;
      mcnt       <= 0;
    end else if (!bus.m_done && mul_hang == 0) begin
      if (mcnt == mul_delay - 1) begin
        bus.m_done <= 1'b1;
        bus.m_p    <= {8'd0, bus.m_a} * {8'd0, bus.m_b};
        mcnt       <= 0;
      end else begin
        mcnt <= mcnt + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  // waits for ack of requester `which`; an expired budget is a failure
  task automatic wait_ack(input int which, input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if ((which == 0) ? bus.ack0 : bus.ack1) break;
      if (n >= budget) begin
        total++;
        bad++;
        $display("FAIL wait_ack%0d: no ack after %0d cycles", which, n);
        break;
      end
    end
  endtask

  // scoreboard monitor
  task automatic monitor();
    logic [W-1:0] got;
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (bus.ack0 || bus.ack1) begin
        total++;
        got = {bus.ack1, bus.p_out};
        if (bus.ack0 && bus.ack1) begin
          bad++;
          $display("FAIL sb_ack_both: got ack0=1 ack1=1 expected one ack");
        end else if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected: got id=%0d p=%0d expected no ack", got[W-1], got[W-2:0]);
        end else begin
          exp = exp_q.pop_front();
          if (got !== exp) begin
            bad++;
            $display("FAIL sb_result: got id=%0d p=%0d expected id=%0d p=%0d",
                     got[W-1], got[W-2:0], exp[W-1], exp[W-2:0]);
          end
        end
      end
    end
  endtask

  initial begin
    int n;
    logic any_g;
    total = 0;
    bad = 0;
    mul_delay = 1;
    mul_hang = 0;
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.a0 = '0;
    bus.b0 = '0;
    bus.a1 = '0;
    bus.b1 = '0;
    fork
      monitor();
    join_none

    // reset state
    do_reset();
    @(negedge clk);
    chk("rst_gnt0", 32'(bus.gnt0), 0);
    chk("rst_gnt1", 32'(bus.gnt1), 0);
    chk("rst_ack0", 32'(bus.ack0), 0);
    chk("rst_ack1", 32'(bus.ack1), 0);
    chk("rst_p_out", 32'(bus.p_out), 0);
    chk("rst_err", 32'(bus.err), 0);
    chk("rst_m_start", 32'(bus.m_start), 0);
    chk("rst_m_a", 32'(bus.m_a), 0);

    // single request, done 20 cycles after start
    mul_delay = 20;
    bus.a0 = 8'd13;
    bus.b0 = 8'd11;
    bus.req0 = 1'b1;
    exp_q.push_back({1'b0, 16'd143});
    @(negedge clk);
    chk("single_gnt0", 32'(bus.gnt0), 1);
    chk("single_m_start", 32'(bus.m_start), 1);
    chk("single_m_a", 32'(bus.m_a), 13);
    chk("single_m_b", 32'(bus.m_b), 11);
    chk("single_gnt1", 32'(bus.gnt1), 0);
    wait_ack(0, 40, n);
    bus.req0 = 1'b0;
    chk("single_latency", 32'(n), 21);
    chk("single_gnt0_in_ack", 32'(bus.gnt0), 1);
    chk("single_gnt1_in_ack", 32'(bus.gnt1), 0);
    @(negedge clk);
    chk("single_ack0_pulse", 32'(bus.ack0), 0);
    cyc(3);

    // tie from reset, then tie again after both served
    do_reset();
    mul_delay = 3;
    bus.a0 = 8'd255;
    bus.b0 = 8'd255;
    bus.a1 = 8'd2;
    bus.b1 = 8'd3;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    exp_q.push_back({1'b0, 16'd65025});
    exp_q.push_back({1'b1, 16'd6});
    wait_ack(0, 20, n);
    bus.req0 = 1'b0;
    wait_ack(1, 20, n);
    bus.req1 = 1'b0;
    cyc(4);
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    exp_q.push_back({1'b0, 16'd65025});
    exp_q.push_back({1'b1, 16'd6});
    @(negedge clk);
    chk("retie_gnt0", 32'(bus.gnt0), 1);
    wait_ack(0, 20, n);
    bus.req0 = 1'b0;
    wait_ack(1, 20, n);
    bus.req1 = 1'b0;
    cyc(4);

    // back-to-back fairness: req0 held, req1 raised during req0's RUN
    do_reset();
    mul_delay = 5;
    bus.a0 = 8'd3;
    bus.b0 = 8'd4;
    bus.a1 = 8'd6;
    bus.b1 = 8'd7;
    bus.req0 = 1'b1;
    exp_q.push_back({1'b0, 16'd12});
    cyc(2);
    bus.req1 = 1'b1;
    exp_q.push_back({1'b1, 16'd42});
    exp_q.push_back({1'b0, 16'd12});
    wait_ack(0, 20, n);
    wait_ack(1, 20, n);
    bus.req1 = 1'b0;
    wait_ack(0, 20, n);
    bus.req0 = 1'b0;
    cyc(4);

    // operand stability after grant
    do_reset();
    mul_delay = 6;
    bus.a0 = 8'd5;
    bus.b0 = 8'd7;
    bus.req0 = 1'b1;
    exp_q.push_back({1'b0, 16'd35});
    @(negedge clk);
    chk("stab_gnt0", 32'(bus.gnt0), 1);
    @(negedge clk);
    bus.a0 = 8'd9;
    @(negedge clk);
    chk("stab_m_a", 32'(bus.m_a), 5);
    wait_ack(0, 20, n);
    bus.req0 = 1'b0;
    chk("stab_m_a_at_ack", 32'(bus.m_a), 5);
    cyc(4);

    // watchdog: multiplier never finishes
    do_reset();
    mul_hang = 1;
    bus.a0 = 8'd4;
    bus.b0 = 8'd4;
    bus.req0 = 1'b1;
    exp_q.push_back({1'b0, 16'd0});
    @(negedge clk);
    chk("wd_start", 32'(bus.m_start), 1);
    n = 0;
    while (bus.m_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("wd_cycles", 32'(n), 64);
    chk("wd_ack0", 32'(bus.ack0), 1);
    chk("wd_err", 32'(bus.err), 1);
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("wd_ack0_pulse", 32'(bus.ack0), 0);
    bus.req1 = 1'b1;
    bus.a1 = 8'd6;
    bus.b1 = 8'd9;
    mul_hang = 0;
    any_g = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      any_g = any_g | bus.gnt0 | bus.gnt1 | bus.m_start;
    end
    chk("halt_no_grant", 32'(any_g), 0);
    chk("halt_err_sticky", 32'(bus.err), 1);
    rst = 1'b0;
    @(negedge clk);
    chk("halt_rst_err", 32'(bus.err), 0);
    chk("halt_rst_no_gnt", 32'(bus.gnt1), 0);
    rst = 1'b1;
    exp_q.push_back({1'b1, 16'd54});
    @(negedge clk);
    chk("post_halt_gnt1", 32'(bus.gnt1), 1);
    wait_ack(1, 20, n);
    bus.req1 = 1'b0;
    cyc(4);

    // reset in the middle of RUN discards the operation
    do_reset();
    mul_delay = 10;
    bus.a0 = 8'd3;
    bus.b0 = 8'd3;
    bus.req0 = 1'b1;
    cyc(3);
    chk("mid_running", 32'(bus.m_start), 1);
    rst = 1'b0;
    bus.req0 = 1'b0;
    @(negedge clk);
    chk("mid_m_start", 32'(bus.m_start), 0);
    chk("mid_gnt0", 32'(bus.gnt0), 0);
    chk("mid_ack0", 32'(bus.ack0), 0);
    chk("mid_m_a", 32'(bus.m_a), 0);
    rst = 1'b1;
    cyc(15);
    bus.a1 = 8'd12;
    bus.b1 = 8'd10;
    bus.req1 = 1'b1;
    exp_q.push_back({1'b1, 16'd120});
    wait_ack(1, 30, n);
    bus.req1 = 1'b0;

    // drain the scoreboard
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    cyc(3);
    chk("sb_empty", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
